nvdla_qch_pr_ctrl: RTL and testbench
====================================

// Module: nvdla_qch_pr_ctrl
// PURPOSE
//  Parametrised device-side Q-channel controller with partial-retention sequencing for NVDLA sub-units (CMAC and successors).
//  Arbitrates quiescence over NUM_BUSY busy sources plus an incoming CSB request.
//  Accepts or denies power-down requests and drives the pr_save/pr_restore strobes to the unit's retention flops.
//  Replaces the per-unit hard-coded Q-channel logic; instantiated once per power domain.
// PARAMETERS
//  NUM_BUSY       4   number of busy_i sources (>=1)
//  IDLE_WAIT      4   consecutive idle cycles in REQUEST before save starts (>=1)
//  RESTORE_CYCLES 2   cycles pr_restore held high on exit (>=1)
//  DENY_TIMEOUT   16  max cycles to wait for busy to clear before denying (only with macro)
// PORTS
//  nvdla_core_clk  in   1         core clock
//  nvdla_core_rstn in   1         async active-low reset
//  qreqn           in   1         Q-channel request, active low
//  busy_i          in   NUM_BUSY  per-source busy, active high
//  csb_req_pvld    in   1         incoming CSB request valid (counts as busy)
//  qacceptn        out  1         Q-channel accept, active low
//  qdeny           out  1         Q-channel deny
//  qactive         out  1         |busy_i | csb_req_pvld, registered
//  pr_save         out  1         one-cycle save strobe to retention flops
//  pr_restore      out  1         restore strobe, RESTORE_CYCLES long
//  clk_gate_en     out  1         high while STOPPED; enables unit clock gating
//  proto_err       out  1         sticky: qreqn rose in REQUEST/SAVE; cleared only by reset
// BEHAVIOUR
//  Reset values: state RUN; qacceptn=1, qdeny=0, qactive=0, pr_save=0, pr_restore=0, clk_gate_en=0, proto_err=0.
//  All outputs are registered; one clock from input change to output.
//  States (qch_state_e):
//   RUN      qreqn=0 -> REQUEST; idle counter cleared.
//   REQUEST  busy or csb_req_pvld -> DENIED (no macro).
//            Otherwise idle_cnt++; idle_cnt==IDLE_WAIT-1 -> SAVE.
//            qreqn=1 -> RUN and proto_err<=1.
//   SAVE     pr_save=1 for exactly one cycle -> STOPPED.
//            qreqn=1 here: complete to STOPPED, then proto_err<=1.
//   STOPPED  qacceptn=0, clk_gate_en=1; qreqn=1 -> RESTORE. Busy is ignored.
//   RESTORE  pr_restore=1 for RESTORE_CYCLES, then -> RUN with qacceptn=1 in the same edge pr_restore falls.
//   DENIED   qdeny=1, qacceptn=1; qreqn=1 -> RUN with qdeny<=0.
//  Protocol guarantees: qacceptn falls only with qreqn=0 & qdeny=0.
//   qacceptn rises only with qreqn=1.
//   qdeny rises only with qreqn=0 & qacceptn=1; qdeny falls only with qreqn=1.
//  pr_save and pr_restore are never high together.
//  pr_restore never rises outside RESTORE.
//  Busy asserting in the same cycle the idle count completes wins: -> DENIED, no save.
//  Mid-operation async reset: immediate RUN values; retention contents are not touched.
//  The idle counter is $clog2(IDLE_WAIT+1) bits wide and saturates, never wraps.
// CONFIGURATION
//  NVDLA_QCH_DENY_TIMEOUT_EN defined:
//   - busy in REQUEST does not deny at once.
//   - A wait counter runs while busy; busy clears -> idle counting restarts from 0.
//   - Wait count reaches DENY_TIMEOUT -> DENIED.
//  Undefined: busy in REQUEST -> DENIED on the next edge; DENY_TIMEOUT unused, no wait counter synthesised.
// STRUCTURE
//  Package nvdla_qch_pkg: qch_state_e (RUN, REQUEST, SAVE, STOPPED, RESTORE, DENIED).
//   Also holds width helper functions shared by the counters.
//  Sub-module nvdla_qch_sat_cnt (WIDTH, MAX; clr, inc, done):
//   - used for the idle count and the restore count;
//   - also used for the deny-timeout count when the macro is defined.
//  Top: FSM, registered output decode, proto_err flop.
// TESTING
//  1 Idle power cycle, IDLE_WAIT=4, RESTORE_CYCLES=2:
//    qreqn falls at t0 -> pr_save at t0+5, qacceptn=0 at t0+6.
//    qreqn rises at t1 -> pr_restore high t1+1..t1+2, qacceptn=1 at t1+3.
//  2 busy_i[2]=1 during REQUEST, no macro:
//    qdeny=1 next cycle, pr_save never pulses.
//    Raising qreqn -> qdeny=0 one cycle later, qacceptn stays 1.
//  3 With NVDLA_QCH_DENY_TIMEOUT_EN and DENY_TIMEOUT=16:
//    busy held 10 cycles, then released -> accept follows IDLE_WAIT cycles later, no deny.
//    busy held 20 cycles -> qdeny=1 after 16 cycles.
//  4 csb_req_pvld=1 on the cycle the idle count reaches IDLE_WAIT-1 -> DENIED, no pr_save.
//  5 qreqn rises in REQUEST -> proto_err=1 and RUN; proto_err stays set until nvdla_core_rstn pulse.
//  6 Async reset asserted while pr_restore=1 -> all outputs at reset values immediately.
//    Next qreqn cycle behaves as scenario 1.
//  Bench must bind SVA for the Q-channel protocol guarantees above on every run.

Source files
------------

// File: rtl/nvdla_qch_pkg.sv
// rtl/nvdla_qch_pkg.sv - shared state type and counter width helper for the Q-channel controller
// Contents:
//   qch_state_e    controller states
//   qch_cnt_width  bits needed to hold the values 0..max_val (minimum 1)
package nvdla_qch_pkg;

    typedef enum logic [2:0] {
        RUN,
        REQUEST,
        SAVE,
        STOPPED,
        RESTORE,
        DENIED
    } qch_state_e;

    function automatic int qch_cnt_width(input int max_val);
        if (max_val < 1) begin
            return 1;
        end
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/nvdla_qch_sat_cnt.sv
// rtl/nvdla_qch_sat_cnt.sv - saturating up-counter with terminal-count flag
// Parameters: WIDTH counter bits, MAX terminal value (counter holds there, never wraps)
// Ports:
//   clk    in   clock
//   rst_n  in   async active-low reset
//   clr    in   synchronous clear, wins over inc
//   inc    in   count enable
//   done   out  counter equals MAX
module nvdla_qch_sat_cnt #(
    parameter int WIDTH = 2,
    parameter int MAX   = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic done
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    logic [WIDTH-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != MAX_V)) begin
            cnt <= cnt + WIDTH'(1);
        end
    end

    assign done = (cnt == MAX_V);

endmodule

// File: rtl/nvdla_qch_pr_ctrl.sv
// rtl/nvdla_qch_pr_ctrl.sv - device-side Q-channel controller with partial-retention save/restore sequencing
// Optional feature macro: NVDLA_QCH_DENY_TIMEOUT_EN (busy in REQUEST waits up to DENY_TIMEOUT cycles before denying)
// Ports:
//   nvdla_core_clk   in   core clock
//   nvdla_core_rstn  in   async active-low reset
//   qreqn            in   Q-channel request, active low
//   busy_i           in   per-source busy, active high
//   csb_req_pvld     in   incoming CSB request valid, treated as busy
//   qacceptn         out  Q-channel accept, active low
//   qdeny            out  Q-channel deny
//   qactive          out  registered OR of all busy sources
//   pr_save          out  one-cycle retention save strobe
//   pr_restore       out  retention restore strobe, RESTORE_CYCLES long
//   clk_gate_en      out  high while stopped
//   proto_err        out  sticky: qreqn withdrawn during REQUEST or SAVE
module nvdla_qch_pr_ctrl
    import nvdla_qch_pkg::*;
#(
    parameter int NUM_BUSY       = 4,
    parameter int IDLE_WAIT      = 4,
    parameter int RESTORE_CYCLES = 2,
    parameter int DENY_TIMEOUT   = 16
) (
    input  logic                nvdla_core_clk,
    input  logic                nvdla_core_rstn,
    input  logic                qreqn,
    input  logic [NUM_BUSY-1:0] busy_i,
    input  logic                csb_req_pvld,
    output logic                qacceptn,
    output logic                qdeny,
    output logic                qactive,
    output logic                pr_save,
    output logic                pr_restore,
    output logic                clk_gate_en,
    output logic                proto_err
);

    localparam int IDLE_W = qch_cnt_width(IDLE_WAIT);
    localparam int REST_W = qch_cnt_width(RESTORE_CYCLES);

    qch_state_e state;
    qch_state_e next_state;

    logic any_busy;
    logic idle_clr;
    logic idle_inc;
    logic idle_done;
    logic rest_clr;
    logic rest_inc;
    logic rest_done;
    logic perr_set;

    assign any_busy = (|busy_i) | csb_req_pvld;

    nvdla_qch_sat_cnt #(
        .WIDTH (IDLE_W),
        .MAX   (IDLE_WAIT - 1)
    ) u_idle_cnt (
        .clk   (nvdla_core_clk),
        .rst_n (nvdla_core_rstn),
        .clr   (idle_clr),
        .inc   (idle_inc),
        .done  (idle_done)
    );

    nvdla_qch_sat_cnt #(
        .WIDTH (REST_W),
        .MAX   (RESTORE_CYCLES - 1)
    ) u_rest_cnt (
        .clk   (nvdla_core_clk),
        .rst_n (nvdla_core_rstn),
        .clr   (rest_clr),
        .inc   (rest_inc),
        .done  (rest_done)
    );

`ifdef NVDLA_QCH_DENY_TIMEOUT_EN
    localparam int WAIT_W = qch_cnt_width(DENY_TIMEOUT);

    logic wait_clr;
    logic wait_inc;
    logic wait_done;

    nvdla_qch_sat_cnt #(
        .WIDTH (WAIT_W),
        .MAX   (DENY_TIMEOUT - 1)
    ) u_wait_cnt (
        .clk   (nvdla_core_clk),
        .rst_n (nvdla_core_rstn),
        .clr   (wait_clr),
        .inc   (wait_inc),
        .done  (wait_done)
    );
`else
    logic unused_deny_timeout;
    assign unused_deny_timeout = (DENY_TIMEOUT != 0);
`endif

    always_comb begin
        next_state = state;
        idle_clr   = 1'b1;
        idle_inc   = 1'b0;
        rest_clr   = 1'b1;
        rest_inc   = 1'b0;
        perr_set   = 1'b0;
`ifdef NVDLA_QCH_DENY_TIMEOUT_EN
        wait_clr   = 1'b1;
        wait_inc   = 1'b0;
`endif
        case (state)
            RUN: begin
                if (!qreqn) begin
                    next_state = REQUEST;
                end
            end
            REQUEST: begin
                idle_clr = 1'b0;
                // Withdrawal is checked before busy so qdeny never rises with qreqn high.
                if (qreqn) begin
                    next_state = RUN;
                    perr_set   = 1'b1;
                end else if (any_busy) begin
                    // Busy is tested before idle_done: a late busy beats the save.
`ifdef NVDLA_QCH_DENY_TIMEOUT_EN
                    idle_clr = 1'b1;
                    wait_clr = 1'b0;
                    wait_inc = 1'b1;
                    if (wait_done) begin
                        next_state = DENIED;
                    end
`else
                    next_state = DENIED;
`endif
                end else if (idle_done) begin
                    next_state = SAVE;
                end else begin
                    idle_inc = 1'b1;
                end
            end
            SAVE: begin
                // The save cannot be aborted once started; a withdrawal here is only flagged.
                next_state = STOPPED;
                if (qreqn) begin
                    perr_set = 1'b1;
                end
            end
            STOPPED: begin
                if (qreqn) begin
                    next_state = RESTORE;
                end
            end
            RESTORE: begin
                rest_clr = 1'b0;
                if (rest_done) begin
                    next_state = RUN;
                end else begin
                    rest_inc = 1'b1;
                end
            end
            DENIED: begin
                if (qreqn) begin
                    next_state = RUN;
                end
            end
            default: begin
                next_state = RUN;
            end
        endcase
    end

    // Outputs are decoded from next_state so they change on the same edge as the state.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state       <= RUN;
            qacceptn    <= 1'b1;
            qdeny       <= 1'b0;
            qactive     <= 1'b0;
            pr_save     <= 1'b0;
            pr_restore  <= 1'b0;
            clk_gate_en <= 1'b0;
            proto_err   <= 1'b0;
        end else begin
            state       <= next_state;
            qacceptn    <= !((next_state == STOPPED) || (next_state == RESTORE));
            qdeny       <= (next_state == DENIED);
            qactive     <= any_busy;
            pr_save     <= (next_state == SAVE);
            pr_restore  <= (next_state == RESTORE);
            clk_gate_en <= (next_state == STOPPED);
            proto_err   <= proto_err | perr_set;
        end
    end

endmodule

// File: tb/tb_nvdla_qch_pr_ctrl.sv
// tb/tb_nvdla_qch_pr_ctrl.sv - self-checking bench for the Q-channel partial-retention controller
module tb_nvdla_qch_pr_ctrl;

    localparam int NB = 4;
    localparam int IW = 4;
    localparam int RC = 2;
    localparam int DT = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          qreqn = 1'b1;
    logic [NB-1:0] busy = '0;
    logic          csb = 1'b0;
    logic          qacceptn;
    logic          qdeny;
    logic          qactive;
    logic          pr_save;
    logic          pr_restore;
    logic          clk_gate_en;
    logic          proto_err;

    int n_cmp = 0;
    int n_bad = 0;

    nvdla_qch_pr_ctrl #(
        .NUM_BUSY       (NB),
        .IDLE_WAIT      (IW),
        .RESTORE_CYCLES (RC),
        .DENY_TIMEOUT   (DT)
    ) dut (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rst_n),
        .qreqn           (qreqn),
        .busy_i          (busy),
        .csb_req_pvld    (csb),
        .qacceptn        (qacceptn),
        .qdeny           (qdeny),
        .qactive         (qactive),
        .pr_save         (pr_save),
        .pr_restore      (pr_restore),
        .clk_gate_en     (clk_gate_en),
        .proto_err       (proto_err)
    );

    always #5 clk = ~clk;

    // Output vector order: {qacceptn, qdeny, qactive, pr_save, pr_restore, clk_gate_en, proto_err}
    localparam logic [6:0] O_RUN  = 7'b1000000;
    localparam logic [6:0] O_SAVE = 7'b1001000;
    localparam logic [6:0] O_STOP = 7'b0000010;
    localparam logic [6:0] O_REST = 7'b0000100;
    localparam logic [6:0] O_DENY = 7'b1100000;
    localparam logic [6:0] O_ACT  = 7'b0010000;
    localparam logic [6:0] O_PERR = 7'b0000001;

    function automatic logic [6:0] outs();
        return {qacceptn, qdeny, qactive, pr_save, pr_restore, clk_gate_en, proto_err};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- protocol assertions ----------------
    a_acc_fall: assert property (@(posedge clk) disable iff (!rst_n)
        ($past(rst_n) && $fell(qacceptn)) |-> ((!$past(qreqn) && !$past(qdeny)) || proto_err))
        else begin n_bad++; $display("FAIL sva_acc_fall at %0t", $time); end
    a_acc_rise: assert property (@(posedge clk) disable iff (!rst_n)
        ($past(rst_n) && $rose(qacceptn)) |-> $past(qreqn))
        else begin n_bad++; $display("FAIL sva_acc_rise at %0t", $time); end
    a_deny_rise: assert property (@(posedge clk) disable iff (!rst_n)
        ($past(rst_n) && $rose(qdeny)) |-> (!$past(qreqn) && $past(qacceptn)))
        else begin n_bad++; $display("FAIL sva_deny_rise at %0t", $time); end
    a_deny_fall: assert property (@(posedge clk) disable iff (!rst_n)
        ($past(rst_n) && $fell(qdeny)) |-> $past(qreqn))
        else begin n_bad++; $display("FAIL sva_deny_fall at %0t", $time); end
    a_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(pr_save && pr_restore))
        else begin n_bad++; $display("FAIL sva_save_restore_overlap at %0t", $time); end
    a_rest_in_restore: assert property (@(posedge clk) disable iff (!rst_n)
        pr_restore |-> (!qacceptn && !clk_gate_en && !qdeny))
        else begin n_bad++; $display("FAIL sva_restore_context at %0t", $time); end

    // ---------------- behavioural reference model ----------------
    bit m_req, m_save, m_stop, m_deny, m_perr, m_act;
    int m_idle, m_rest, m_wait;

    task automatic model_reset();
        m_req = 0; m_save = 0; m_stop = 0; m_deny = 0; m_perr = 0; m_act = 0;
        m_idle = 0; m_rest = 0; m_wait = 0;
    endtask

    function automatic logic [6:0] model_outs();
        return {!(m_stop || (m_rest > 0)), m_deny, m_act, m_save, (m_rest > 0), m_stop, m_perr};
    endfunction

    task automatic model_step(input bit q, input bit b);
        m_act = b;
        if (m_rest > 0) begin
            m_rest--;
        end else if (m_save) begin
            m_save = 0;
            m_stop = 1;
            if (q) m_perr = 1;
        end else if (m_stop) begin
            if (q) begin
                m_stop = 0;
                m_rest = RC;
            end
        end else if (m_deny) begin
            if (q) m_deny = 0;
        end else if (m_req) begin
            if (q) begin
                m_req = 0;
                m_perr = 1;
            end else if (b) begin
`ifdef NVDLA_QCH_DENY_TIMEOUT_EN
                m_idle = 0;
                m_wait++;
                if (m_wait == DT) begin
                    m_req = 0;
                    m_deny = 1;
                end
`else
                m_req = 0;
                m_deny = 1;
`endif
            end else begin
                m_wait = 0;
                m_idle++;
                if (m_idle == IW) begin
                    m_req = 0;
                    m_save = 1;
                end
            end
        end else if (!q) begin
            m_req = 1;
            m_idle = 0;
            m_wait = 0;
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic          q;
        logic [NB-1:0] b;
        logic          c;
        logic [6:0]    exp;
    } vec_t;

    vec_t vt[20];

    task automatic row(input int i, input logic q, input logic [NB-1:0] b, input logic c,
                       input logic [6:0] e);
        vt[i].q = q; vt[i].b = b; vt[i].c = c; vt[i].exp = e;
    endtask

    // Called at a negedge: drive row inputs, check outputs one edge later.
    task automatic apply_rows(input int first, input int last, input string tag);
        for (int i = first; i <= last; i++) begin
            qreqn = vt[i].q;
            busy  = vt[i].b;
            csb   = vt[i].c;
            @(negedge clk);
            chk($sformatf("%s_row%0d", tag, i), outs(), vt[i].exp);
        end
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // Scenario 1: idle power cycle
        row(0,  1'b0, 4'b0000, 1'b0, O_RUN);
        row(1,  1'b0, 4'b0000, 1'b0, O_RUN);
        row(2,  1'b0, 4'b0000, 1'b0, O_RUN);
        row(3,  1'b0, 4'b0000, 1'b0, O_RUN);
        row(4,  1'b0, 4'b0000, 1'b0, O_SAVE);
        row(5,  1'b0, 4'b0000, 1'b0, O_STOP);
        row(6,  1'b0, 4'b0100, 1'b0, O_STOP | O_ACT);
        row(7,  1'b1, 4'b0000, 1'b0, O_REST);
        row(8,  1'b1, 4'b0000, 1'b0, O_REST);
        row(9,  1'b1, 4'b0000, 1'b0, O_RUN);
        // Scenario 2: busy during REQUEST denies
        row(10, 1'b0, 4'b0000, 1'b0, O_RUN);
        row(11, 1'b0, 4'b0100, 1'b0, O_DENY | O_ACT);
        row(12, 1'b0, 4'b0000, 1'b0, O_DENY);
        row(13, 1'b1, 4'b0000, 1'b0, O_RUN);
        // Scenario 4: CSB request on the final idle count wins over save
        row(14, 1'b0, 4'b0000, 1'b0, O_RUN);
        row(15, 1'b0, 4'b0000, 1'b0, O_RUN);
        row(16, 1'b0, 4'b0000, 1'b0, O_RUN);
        row(17, 1'b0, 4'b0000, 1'b0, O_RUN);
        row(18, 1'b0, 4'b0000, 1'b1, O_DENY | O_ACT);
        row(19, 1'b1, 4'b0000, 1'b0, O_RUN);

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outs", outs(), O_RUN);
        rst_n = 1'b1;

`ifndef NVDLA_QCH_DENY_TIMEOUT_EN
        apply_rows(0, 19, "table");
`else
        apply_rows(0, 9, "table");
`endif

        // Scenario 5: withdrawal during REQUEST is sticky until reset
        qreqn = 1'b0;
        @(negedge clk);
        qreqn = 1'b1;
        @(negedge clk);
        chk("perr_req_abort", outs(), O_RUN | O_PERR);
        repeat (6) @(negedge clk);
        chk("perr_sticky", proto_err, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("perr_cleared_by_reset", outs(), O_RUN);
        @(negedge clk);
        rst_n = 1'b1;

        // Withdrawal during SAVE: save completes, then restore, error flagged
        qreqn = 1'b0;
        repeat (5) @(negedge clk);
        chk("save_strobe", outs(), O_SAVE);
        qreqn = 1'b1;
        @(negedge clk);
        chk("save_abort_stop", outs(), O_STOP | O_PERR);
        @(negedge clk);
        chk("save_abort_rest1", outs(), O_REST | O_PERR);
        @(negedge clk);
        chk("save_abort_rest2", outs(), O_REST | O_PERR);
        @(negedge clk);
        chk("save_abort_run", outs(), O_RUN | O_PERR);
        pulse_reset();

        // Scenario 6: async reset while pr_restore is high
        qreqn = 1'b0;
        repeat (6) @(negedge clk);
        chk("pre_reset_stopped", outs(), O_STOP);
        qreqn = 1'b1;
        @(negedge clk);
        chk("pre_reset_restore", pr_restore, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outs", outs(), O_RUN);
        @(negedge clk);
        rst_n = 1'b1;
        apply_rows(0, 9, "after_reset");

`ifdef NVDLA_QCH_DENY_TIMEOUT_EN
        // Scenario 3a: busy for a while then released -> accepted, no deny
        pulse_reset();
        qreqn = 1'b0;
        busy  = 4'b0001;
        repeat (11) @(negedge clk);
        chk("to_busy10_no_deny", qdeny, 1'b0);
        busy = '0;
        repeat (IW) @(negedge clk);
        chk("to_release_save", pr_save, 1'b1);
        @(negedge clk);
        chk("to_release_accept", qacceptn, 1'b0);
        qreqn = 1'b1;
        repeat (RC + 1) @(negedge clk);
        chk("to_release_back_run", outs(), O_RUN);
        // Scenario 3b: busy held past the timeout -> deny after DT busy cycles
        qreqn = 1'b0;
        @(negedge clk);
        busy = 4'b1000;
        repeat (DT - 1) @(negedge clk);
        chk("to_before_deny", qdeny, 1'b0);
        @(negedge clk);
        chk("to_deny", qdeny, 1'b1);
        busy  = '0;
        qreqn = 1'b1;
        @(negedge clk);
        chk("to_deny_cleared", outs(), O_RUN);
`endif

        // Randomized run against the reference model
        pulse_reset();
        model_reset();
        qreqn = 1'b1;
        busy  = '0;
        csb   = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic [6:0] mo;
            mo = model_outs();
            if (qreqn) begin
                if (mo[6] && !m_deny && ($urandom % 4 == 0)) qreqn = 1'b0;
            end else begin
                if ((m_stop || m_deny) && ($urandom % 4 == 0)) qreqn = 1'b1;
                else if ((m_req || m_save) && ($urandom % 60 == 0)) qreqn = 1'b1;
            end
            busy = ($urandom % 6 == 0) ? NB'($urandom) : '0;
            csb  = ($urandom % 12 == 0);
            model_step(qreqn, (|busy) | csb);
            @(negedge clk);
            chk($sformatf("rand_cyc%0d", cyc), outs(), model_outs());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
